// File: rtl/nist_stream_driver_if.sv
// nist_stream_driver_if: valid/ready word channel from the PUF response source to the stream driver
//   word_in    : response word, driven by the source
//   word_valid : word_in holds a word, driven by the source
//   word_ready : the driver can take a word this cycle, driven by the driver
interface nist_stream_driver_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;
    modport master (output word_in, output word_valid, input word_ready);
    modport slave (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/nist_stream_driver.sv
// nist_stream_driver: serialises PUF response words MSB first into a NIST test bank and latches its pass vector
//   clk, rst        : clock, asynchronous active-high reset
//   start           : begin a session (taken only when idle)
//   wb              : word channel (word_in / word_valid / word_ready)
//   rand_out        : one serial bit per cycle to the bank
//   test_rst        : bank reset, high outside the streaming and settle window
//   test_result_in  : bank pass vector, sampled at the end of settle
//   result          : latched pass vector, result_valid marks a completed session
//   underrun        : session aborted because no word was available in time
//   busy, done      : session in progress, one-cycle end-of-session pulse
module nist_stream_driver #(
    parameter int WORD_W     = 32,
    parameter int SEQ_LEN    = 20000,
    parameter int CNT_W      = 16,
    parameter int RST_CYC    = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    nist_stream_driver_if.slave wb,
    output logic                rand_out,
    output logic                test_rst,
    input  logic [7:0]          test_result_in,
    output logic [7:0]          result,
    output logic                result_valid,
    output logic                underrun,
    output logic                busy,
    output logic                done
);
    localparam int SW = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LEN = CNT_W'(SEQ_LEN);
    localparam logic [CNT_W-1:0] RST_N = CNT_W'(RST_CYC);
    localparam logic [CNT_W-1:0] SET_N = CNT_W'(SETTLE_CYC - 1);
    localparam logic [SW-1:0] LAST_SH = SW'(WORD_W - 1);
    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, SETTLE} state_t;
    state_t            state_q, state_d;
    logic [WORD_W-1:0] sh_q, sh_d, hold_q, hold_d, src;
    logic [SW-1:0]     sh_cnt_q, sh_cnt_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d, cyc_q, cyc_d;
    logic [7:0]        res_q, res_d;
    logic              hold_vld_q, hold_vld_d, rand_q, rand_d, trst_q, trst_d, ready_q, ready_d;
    logic              rv_q, rv_d, und_q, und_d, done_q, done_d, acc, fin;
    // rand_out always shows the bit for the current cycle, so each word's MSB is
    // loaded straight into rand_out and sh only keeps the bits still to come
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        sh_cnt_d   = sh_cnt_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        bit_cnt_d  = bit_cnt_q;
        cyc_d      = cyc_q;
        rand_d     = rand_q;
        trst_d     = trst_q;
        res_d      = res_q;
        rv_d       = rv_q;
        und_d      = und_q;
        done_d     = 1'b0;
        acc        = wb.word_valid && ready_q;
        src        = hold_vld_q ? hold_q : wb.word_in;
        fin        = (state_q == STREAM && bit_cnt_q == LEN && SETTLE_CYC == 1) ||
                     (state_q == SETTLE && cyc_q == SET_N);
        case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    state_d = CLEAR;
                    cyc_d   = CNT_W'(1);
                    res_d   = 8'h00;
                    rv_d    = 1'b0;
                    und_d   = 1'b0;
                end
            end
            CLEAR: begin
                if (acc) begin
                    hold_d     = wb.word_in;
                    hold_vld_d = 1'b1;
                end
                if (cyc_q >= RST_N && hold_vld_q) begin
                    state_d    = STREAM;
                    rand_d     = hold_q[WORD_W-1];
                    sh_d       = hold_q << 1;
                    sh_cnt_d   = LAST_SH;
                    bit_cnt_d  = CNT_W'(1);
                    hold_vld_d = 1'b0;
                    trst_d     = 1'b0;
                end else if (cyc_q < RST_N) begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            STREAM: begin
                if (bit_cnt_q == LEN) begin
                    state_d    = SETTLE;
                    hold_vld_d = 1'b0;
                    rand_d     = 1'b0;
                    cyc_d      = CNT_W'(1);
                end else if (sh_cnt_q != '0) begin
                    rand_d    = sh_q[WORD_W-1];
                    sh_d      = sh_q << 1;
                    sh_cnt_d  = sh_cnt_q - 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (acc) begin
                        hold_d     = wb.word_in;
                        hold_vld_d = 1'b1;
                    end
                end else if (hold_vld_q || acc) begin
                    // refill from hold, or bypass a word arriving right now
                    rand_d     = src[WORD_W-1];
                    sh_d       = src << 1;
                    sh_cnt_d   = LAST_SH;
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    hold_vld_d = 1'b0;
                end else begin
                    state_d = IDLE;
                    rand_d  = 1'b0;
                    trst_d  = 1'b1;
                    und_d   = 1'b1;
                    done_d  = 1'b1;
                end
            end
            SETTLE: cyc_d = cyc_q + 1'b1;
        endcase
        if (fin) begin
            state_d = IDLE;
            res_d   = test_result_in;
            rv_d    = 1'b1;
            done_d  = 1'b1;
            trst_d  = 1'b1;
        end
        // no word is taken once the last bit is on the wire
        ready_d = (state_d == CLEAR || (state_d == STREAM && bit_cnt_d != LEN)) && !hold_vld_d;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            sh_cnt_q   <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            bit_cnt_q  <= '0;
            cyc_q      <= '0;
            rand_q     <= 1'b0;
            trst_q     <= 1'b1;
            ready_q    <= 1'b0;
            res_q      <= 8'h00;
            rv_q       <= 1'b0;
            und_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            sh_cnt_q   <= sh_cnt_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            bit_cnt_q  <= bit_cnt_d;
            cyc_q      <= cyc_d;
            rand_q     <= rand_d;
            trst_q     <= trst_d;
            ready_q    <= ready_d;
            res_q      <= res_d;
            rv_q       <= rv_d;
            und_q      <= und_d;
            done_q     <= done_d;
        end
    end
    assign wb.word_ready  = ready_q;
    assign rand_out       = rand_q;
    assign test_rst       = trst_q;
    assign result         = res_q;
    assign result_valid   = rv_q;
    assign underrun       = und_q;
    assign done           = done_q;
    assign busy           = state_q != IDLE || done_q;
endmodule
